// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture
//   Measures the high-pulse width of a hobby-servo PWM input in whole
//   microseconds. It checks the width against an accepted range and tracks
//   whether a valid signal is currently present.
//
// Ports
//   CLK        in   system clock; all logic runs on its rising edge
//   RST_N      in   asynchronous active-low reset
//   PMOD       in   asynchronous servo PWM input (high pulse, ~20 ms frame)
//   pulse_us   out  [11:0] last accepted high-pulse width in us
//   valid      out  one-cycle strobe: pulse_us updated this cycle
//   range_err  out  one-cycle strobe: pulse rejected as out of range
//   locked     out  a valid pulse was accepted and no timeout since
module servo_pwm_capture #(
  parameter int TICKS_PER_US = 25,
  parameter int MIN_US       = 500,
  parameter int MAX_US       = 2700,
  parameter int TIMEOUT_US   = 25000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PMOD,
  output logic [11:0] pulse_us,
  output logic        valid,
  output logic        range_err,
  output logic        locked
);

  localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int WW = $clog2(TIMEOUT_US + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_US - 1);
  localparam logic [11:0]   MIN_L      = 12'(MIN_US);
  localparam logic [11:0]   MAX_L      = 12'(MAX_US);
  localparam logic [11:0]   US_SAT     = 12'hFFF;
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_US);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH} state_t;

  state_t        state;
  logic          pmod_p0, pmod_p1, pmod_p2;
  logic          fill_p0, fill_p1;
  logic [PW-1:0] presc;
  logic [11:0]   us_cnt;
  logic [PW-1:0] wd_presc;
  logic [WW-1:0] wd_cnt;

  logic          synced, rise, fall;
  logic          presc_wrap, wd_wrap;
  logic [PW-1:0] presc_nxt, wd_presc_nxt;
  logic [11:0]   us_nxt;
  logic [WW-1:0] wd_cnt_nxt;

  // Stage p1 is the synchronized input; p2 is its previous value.
  assign synced = pmod_p1;
  assign rise   = pmod_p1 & ~pmod_p2;
  assign fall   = ~pmod_p1 & pmod_p2;

  // The width counter keeps running in the fall cycle too. As a result, the
  // value used at the fall equals floor(high cycles / TICKS_PER_US). The rise
  // cycle, which clears the counters, is itself one of the high cycles.
  always_comb begin
    presc_wrap   = (presc == PRESC_LAST);
    presc_nxt    = presc_wrap ? '0 : presc + PW'(1);
    us_nxt       = (presc_wrap && (us_cnt != US_SAT)) ? us_cnt + 12'd1 : us_cnt;
    wd_wrap      = (wd_presc == PRESC_LAST);
    wd_presc_nxt = wd_wrap ? '0 : wd_presc + PW'(1);
    wd_cnt_nxt   = (wd_wrap && (wd_cnt != WD_LAST)) ? wd_cnt + WW'(1) : wd_cnt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      pmod_p0   <= 1'b0;
      pmod_p1   <= 1'b0;
      pmod_p2   <= 1'b0;
      fill_p0   <= 1'b0;
      fill_p1   <= 1'b0;
      presc     <= '0;
      us_cnt    <= '0;
      wd_presc  <= '0;
      wd_cnt    <= '0;
      pulse_us  <= '0;
      valid     <= 1'b0;
      range_err <= 1'b0;
      locked    <= 1'b0;
    end else begin
      // Synchronizer stages p0 -> p1 -> p2.
      pmod_p0   <= PMOD;
      pmod_p1   <= pmod_p0;
      pmod_p2   <= pmod_p1;
      // fill_p1 marks the point where pmod_p1 holds a real sample and no
      // longer a reset value. Without it, a line that is already high at
      // reset release would look like a fresh rise.
      fill_p0   <= 1'b1;
      fill_p1   <= fill_p0;
      valid     <= 1'b0;
      range_err <= 1'b0;

      case (state)
        IDLE: begin
          if (fill_p1 && !synced) state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            presc  <= '0;
            us_cnt <= '0;
            state  <= HIGH;
          end
        end
        HIGH: begin
          presc  <= presc_nxt;
          us_cnt <= us_nxt;
          if (fall) begin
            if ((us_nxt >= MIN_L) && (us_nxt <= MAX_L)) begin
              pulse_us <= us_nxt;
              valid    <= 1'b1;
              locked   <= 1'b1;
            end else begin
              range_err <= 1'b1;
            end
            state <= WAIT_RISE;
          end else if (us_nxt > MAX_L) begin
            // Still high past the maximum: reject now, then wait for the
            // line to go low before arming again.
            range_err <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Watchdog: a free-running us counter, cleared by every rise. A rise
      // in the expiry cycle takes priority, so locked is left untouched.
      if (rise) begin
        wd_presc <= '0;
        wd_cnt   <= '0;
      end else begin
        wd_presc <= wd_presc_nxt;
        wd_cnt   <= wd_cnt_nxt;
        if (wd_cnt_nxt == WD_LAST) locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Testbench for servo_pwm_capture, using scaled-down parameters so that the
// run stays short: 4 ticks/us, 10..50 us accepted range, 200 us timeout.
// The PMOD input changes on falling clock edges and outputs are sampled on
// falling clock edges.
module tb_servo_pwm_capture;

  localparam int T    = 4;
  localparam int MINU = 10;
  localparam int MAXU = 50;
  localparam int TO   = 200;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        PMOD;
  logic [11:0] pulse_us;
  logic        valid;
  logic        range_err;
  logic        locked;

  int n_chk  = 0;
  int n_fail = 0;

  servo_pwm_capture #(
    .TICKS_PER_US(T),
    .MIN_US(MINU),
    .MAX_US(MAXU),
    .TIMEOUT_US(TO)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .PMOD(PMOD),
    .pulse_us(pulse_us),
    .valid(valid),
    .range_err(range_err),
    .locked(locked)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int hi;   // high cycles
    int lo;   // low cycles after the pulse
    int nv;   // expected valid strobes
    int nr;   // expected range_err strobes
    int pu;   // expected pulse_us afterwards
    int lk;   // expected locked afterwards
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Call on a falling edge: one high pulse of hi cycles, then lo low cycles.
  task automatic run_pulse(input int hi, input int lo,
                           output int nv, output int nr, output int nb);
    nv = 0;
    nr = 0;
    nb = 0;
    PMOD = 1'b1;
    for (int i = 0; i < hi + lo; i++) begin
      @(negedge CLK);
      if (valid) nv++;
      if (range_err) nr++;
      if (valid && range_err) nb++;
      if (i == hi - 1) PMOD = 1'b0;
    end
  endtask

  initial begin
    int nv, nr, nb, lat, cnt;

    // hi,  lo, nv, nr, pulse_us, locked
    vecs[0]  = '{120, 40, 1, 0, 30, 1};  // nominal 30 us
    vecs[1]  = '{123, 40, 1, 0, 30, 1};  // floor: 30.75 us -> 30
    vecs[2]  = '{124, 40, 1, 0, 31, 1};  // exactly 31 us
    vecs[3]  = '{ 40, 40, 1, 0, 10, 1};  // minimum accepted
    vecs[4]  = '{ 39, 40, 0, 1, 10, 1};  // 9 us: too short, pulse_us held
    vecs[5]  = '{200, 40, 1, 0, 50, 1};  // maximum accepted
    vecs[6]  = '{203, 40, 1, 0, 50, 1};  // 50.75 us still 50
    vecs[7]  = '{204, 40, 0, 1, 50, 1};  // 51 us reached at the fall
    vecs[8]  = '{260, 40, 0, 1, 50, 1};  // runs past max while high
    vecs[9]  = '{120, 40, 1, 0, 30, 1};  // accepted after over-max abort
    vecs[10] = '{ 44, 40, 1, 0, 11, 1};

    RST_N = 1'b0;
    PMOD  = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_pulse_us", int'(pulse_us), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_range_err", int'(range_err), 0);
    chk("reset_locked", int'(locked), 0);
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    chk("idle_locked", int'(locked), 0);

    for (int v = 0; v < 11; v++) begin
      run_pulse(vecs[v].hi, vecs[v].lo, nv, nr, nb);
      chk($sformatf("vec%0d_valid_cnt", v), nv, vecs[v].nv);
      chk($sformatf("vec%0d_range_cnt", v), nr, vecs[v].nr);
      chk($sformatf("vec%0d_both", v), nb, 0);
      chk($sformatf("vec%0d_pulse_us", v), int'(pulse_us), vecs[v].pu);
      chk($sformatf("vec%0d_locked", v), int'(locked), vecs[v].lk);
    end

    // Latency: valid appears on the 3rd rising edge after PMOD goes low.
    PMOD = 1'b1;
    repeat (120) @(negedge CLK);
    PMOD = 1'b0;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!valid && lat < 20);
    chk("latency_edges", lat, 3);
    chk("latency_pulse_us", int'(pulse_us), 30);
    repeat (40) @(negedge CLK);

    // Watchdog: the rise is seen on the 3rd edge after PMOD rises; locked
    // drops TO*T = 800 edges after that, i.e. at edge 803.
    PMOD = 1'b1;
    cnt = 0;
    while (cnt < 2000) begin
      @(negedge CLK);
      cnt++;
      if (!locked) break;
      if (cnt == 120) PMOD = 1'b0;
    end
    chk("timeout_edges", cnt, 803);
    repeat (20) @(negedge CLK);
    chk("timeout_locked_stays", int'(locked), 0);
    chk("timeout_pulse_hold", int'(pulse_us), 30);
    run_pulse(120, 40, nv, nr, nb);
    chk("relock_valid_cnt", nv, 1);
    chk("relock_locked", int'(locked), 1);

    // Reset 10 us into a pulse; the line is still high at release.
    PMOD = 1'b1;
    repeat (40) @(negedge CLK);
    #1 RST_N = 1'b0;
    #1;
    chk("midreset_pulse_us", int'(pulse_us), 0);
    chk("midreset_valid", int'(valid), 0);
    chk("midreset_range_err", int'(range_err), 0);
    chk("midreset_locked", int'(locked), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    nv = 0;
    nr = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (valid) nv++;
      if (range_err) nr++;
      if (i == 39) PMOD = 1'b0;
    end
    chk("partial_valid_cnt", nv, 0);
    chk("partial_range_cnt", nr, 0);
    run_pulse(120, 40, nv, nr, nb);
    chk("after_reset_valid_cnt", nv, 1);
    chk("after_reset_pulse_us", int'(pulse_us), 30);
    chk("after_reset_locked", int'(locked), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
